// File: rtl/sum_accumulator.sv
// Sums CNT_MAX consecutive 5-bit adder results ({carry, sum}) into an ACC_W-bit total
// and hands the total downstream on a valid/ready port, with a sticky overflow flag.
module sum_accumulator #(
   parameter int ACC_W   = 8,
   parameter int CNT_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sum,
   input  logic             in_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             ovf;
   logic [ACC_W:0]   sum_ext;
   logic             in_xfer;
   logic             out_xfer;
   logic             last_sample;

   assign in_xfer     = in_valid && in_ready;
   assign out_xfer    = out_valid && out_ready;
   assign last_sample = (cnt == 8'(CNT_MAX - 1));
   assign sum_ext     = {1'b0, acc} + (ACC_W + 1)'({in_co, in_sum});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // IDLE always holds cnt=0, so the same last-sample test covers CNT_MAX==1.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, ACC: begin
            if (in_xfer) begin
               state_next = last_sample ? DONE : ACC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (clr) begin
         state_next = IDLE;
      end
   end

   always_comb begin
      in_ready  = (state != DONE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath; clr wins over a same-cycle input transfer so that sample is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (in_xfer) begin
         acc <= sum_ext[ACC_W-1:0];
         cnt <= cnt + 8'd1;
         ovf <= ovf | sum_ext[ACC_W];
      end else if (out_xfer) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

   assign out_acc = acc;
   assign out_ovf = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a default instance and an ACC_W=6 instance share
// one stimulus stream, so the overflow case can be seen on the narrow accumulator.
module tb_sum_accumulator;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic [3:0] in_sum;
   logic       in_co;
   logic       out_ready;

   logic       in_ready8, out_valid8, out_ovf8, busy8;
   logic [7:0] out_acc8;
   logic       in_ready6, out_valid6, out_ovf6, busy6;
   logic [5:0] out_acc6;

   int testsRun;
   int testsFailed;

   sum_accumulator #(.ACC_W(8), .CNT_MAX(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready8), .in_sum(in_sum), .in_co(in_co),
      .out_valid(out_valid8), .out_ready(out_ready), .out_acc(out_acc8),
      .out_ovf(out_ovf8), .busy(busy8)
   );

   sum_accumulator #(.ACC_W(6), .CNT_MAX(4)) dut6 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready6), .in_sum(in_sum), .in_co(in_co),
      .out_valid(out_valid6), .out_ready(out_ready), .out_acc(out_acc6),
      .out_ovf(out_ovf6), .busy(busy6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Presents one cycle of input, then returns 1 time unit after the edge.
   task automatic applyStimulus(input logic valid, input logic [4:0] value);
      in_valid = valid;
      {in_co, in_sum} = value;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [4:0] basicStream [4];
      basicStream = '{5'd13, 5'd12, 5'd14, 5'd31};
      testsRun    = 0;
      testsFailed = 0;
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_sum    = 4'd0;
      in_co     = 1'b0;
      out_ready = 1'b1;

      #3;
      checkOutput("reset in_ready", in_ready8, 1);
      checkOutput("reset out_valid", out_valid8, 0);
      checkOutput("reset out_acc", out_acc8, 0);
      checkOutput("reset out_ovf", out_ovf8, 0);
      checkOutput("reset busy", busy8, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] basic block");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, basicStream[i]);
         checkOutput("basic out_valid", out_valid8, (i == 3) ? 1 : 0);
         checkOutput("basic busy", busy8, 1);
      end
      checkOutput("basic out_acc", out_acc8, 32'h46);
      checkOutput("basic out_ovf", out_ovf8, 0);
      checkOutput("basic in_ready in DONE", in_ready8, 0);
      applyStimulus(1'b0, 5'd0);
      checkOutput("basic out_valid one cycle", out_valid8, 0);
      checkOutput("basic out_acc cleared", out_acc8, 0);
      checkOutput("basic busy cleared", busy8, 0);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, basicStream[i]);
      checkOutput("bp out_valid rise", out_valid8, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 5'd9);
         checkOutput("bp out_valid held", out_valid8, 1);
         checkOutput("bp out_acc held", out_acc8, 32'h46);
         checkOutput("bp in_ready low", in_ready8, 0);
      end
      out_ready = 1'b1;
      applyStimulus(1'b1, 5'd9);
      checkOutput("bp out_valid drop", out_valid8, 0);
      checkOutput("bp in_ready back", in_ready8, 1);
      checkOutput("bp out_acc cleared", out_acc8, 0);

      $display("[TB] overflow");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd31);
      checkOutput("ovf6 out_valid", out_valid6, 1);
      checkOutput("ovf6 out_acc", out_acc6, 60);
      checkOutput("ovf6 out_ovf", out_ovf6, 1);
      checkOutput("ovf8 out_acc", out_acc8, 124);
      checkOutput("ovf8 out_ovf", out_ovf8, 0);
      applyStimulus(1'b0, 5'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd1);
      checkOutput("ovf6 next out_acc", out_acc6, 4);
      checkOutput("ovf6 next out_ovf", out_ovf6, 0);
      applyStimulus(1'b0, 5'd0);

      $display("[TB] gapped input");
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i % 2) == 0, 5'd5);
         checkOutput("gap out_valid", out_valid8, (i == 6) ? 1 : 0);
         if (i == 6) checkOutput("gap out_acc", out_acc8, 20);
      end

      $display("[TB] clr mid-block");
      applyStimulus(1'b1, 5'd10);
      applyStimulus(1'b1, 5'd10);
      checkOutput("clr pre acc", out_acc8, 20);
      clr = 1'b1;
      applyStimulus(1'b1, 5'd7);
      clr = 1'b0;
      checkOutput("clr busy", busy8, 0);
      checkOutput("clr out_acc", out_acc8, 0);
      checkOutput("clr in_ready", in_ready8, 1);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i));
      checkOutput("clr after out_valid", out_valid8, 1);
      checkOutput("clr after out_acc", out_acc8, 10);
      applyStimulus(1'b0, 5'd0);

      $display("[TB] async reset");
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd3);
      checkOutput("arst pre out_valid", out_valid8, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst out_valid", out_valid8, 0);
      checkOutput("arst out_acc", out_acc8, 0);
      checkOutput("arst in_ready", in_ready8, 1);
      checkOutput("arst busy", busy8, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b1, 5'd2);
      applyStimulus(1'b1, 5'd4);
      applyStimulus(1'b1, 5'd6);
      checkOutput("arst resume early", out_valid8, 0);
      applyStimulus(1'b1, 5'd8);
      checkOutput("arst resume out_valid", out_valid8, 1);
      checkOutput("arst resume out_acc", out_acc8, 20);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
